score_timer_display: RTL

Downstream consumer of the game core. It counts TARGET_REACHED pulses from the snake controller as a two-digit BCD score. In timed mode it runs a GAME_SECONDS countdown and flags win or time-up to the master state machine. It multiplexes score and time onto the Basys-3 4-digit seven-segment display, and sits beside the VGA path in the top-level wrapper.

---
 rtl/snake_pkg.sv | 26 ++
 rtl/seg7_decoder.sv | 31 +++
 rtl/score_timer_display.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/snake_pkg.sv
// Shared encodings for the snake game blocks: master-state codes, the
// score/timer FSM states and seven-segment constants.
package snake_pkg;

    localparam logic [1:0] MSM_START = 2'd0;
    localparam logic [1:0] MSM_PLAY  = 2'd1;
    localparam logic [1:0] MSM_END_W = 2'd2;
    localparam logic [1:0] MSM_END_L = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } fsm_state_e;

    typedef enum logic [1:0] {
        SEG_MODE_DIGIT,
        SEG_MODE_BLANK,
        SEG_MODE_DASH
    } seg_mode_e;

    // Active-low {dp,g..a}: all off, and segment g only.
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_DASH  = 8'hBF;

endpackage

// File: rtl/seg7_decoder.sv
// BCD digit to active-low seven-segment pattern, with blank and dash overrides.
module seg7_decoder
    import snake_pkg::*;
(
    input  logic [3:0] bcd_i,
    input  seg_mode_e  mode_i,
    output logic [7:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        if (mode_i == SEG_MODE_DASH) begin
            seg_o = SEG_DASH;
        end else if (mode_i == SEG_MODE_DIGIT) begin
            case (bcd_i)
                4'd0:    seg_o = 8'hC0;
                4'd1:    seg_o = 8'hF9;
                4'd2:    seg_o = 8'hA4;
                4'd3:    seg_o = 8'hB0;
                4'd4:    seg_o = 8'h99;
                4'd5:    seg_o = 8'h92;
                4'd6:    seg_o = 8'h82;
                4'd7:    seg_o = 8'hF8;
                4'd8:    seg_o = 8'h80;
                4'd9:    seg_o = 8'h90;
                default: seg_o = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/score_timer_display.sv
// BCD score counter, timed-mode countdown with win/time-up flags, and the
// four-digit multiplexed seven-segment driver for score and seconds.
module score_timer_display
    import snake_pkg::*;
#(
    parameter int CLK_HZ       = 100_000_000,
    parameter int GAME_SECONDS = 60,
    parameter int TARGET_SCORE = 10,
    parameter int REFRESH_DIV  = 100_000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [1:0] MSM_STATE,
    input  logic       TIMED_MODE,
    input  logic       TARGET_REACHED,
    output logic [7:0] SCORE,
    output logic       WIN,
    output logic       TIME_UP,
    output logic [3:0] SEG_SELECT,
    output logic [7:0] HEX_OUT
);

    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [7:0] SEC_INIT = 8'(((GAME_SECONDS / 10) << 4) + (GAME_SECONDS % 10));
    localparam logic [7:0] TGT_BCD  = 8'(((TARGET_SCORE / 10) << 4) + (TARGET_SCORE % 10));

    function automatic logic [7:0] bcd_inc_sat(input logic [7:0] v);
        if (v == 8'h99)         return v;
        else if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
        else                     return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        if (v == 8'h00)          return v;
        else if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
        else                     return {v[7:4], v[3:0] - 4'd1};
    endfunction

    fsm_state_e    state_q, state_d;
    logic          mode_q, mode_d;
    logic          tr_q, edge_q;
    logic [7:0]    score_q, score_d;
    logic [7:0]    sec_q, sec_d, sec_dec;
    logic [PW-1:0] presc_q, presc_d;
    logic          win_q, win_d, tup_q, tup_d;
    logic [RW-1:0] ref_q, ref_d;
    logic [1:0]    digit_q, digit_d;
    logic [3:0]    sel_q, sel_d;
    logic [7:0]    hex_q, hex_d;
    logic [3:0]    nib;
    seg_mode_e     nib_mode;

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        score_d = score_q;
        sec_d   = sec_q;
        presc_d = presc_q;
        win_d   = win_q;
        tup_d   = tup_q;
        sec_dec = bcd_dec(sec_q);
        case (state_q)
            ST_IDLE: begin
                score_d = 8'h00;
                sec_d   = SEC_INIT;
                presc_d = '0;
                win_d   = 1'b0;
                tup_d   = 1'b0;
                mode_d  = TIMED_MODE;
                if (MSM_STATE == MSM_PLAY) state_d = ST_RUN;
            end
            ST_RUN: begin
                // Once the target is on SCORE everything freezes; WIN follows a cycle later.
                if (mode_q && score_q == TGT_BCD) begin
                    win_d = 1'b1;
                end else begin
                    if (edge_q) score_d = bcd_inc_sat(score_q);
                    if (mode_q) begin
                        if (presc_q == PW'(CLK_HZ - 1)) begin
                            presc_d = '0;
                            sec_d   = sec_dec;
                            // A score reaching the target on the final tick wins instead.
                            if (sec_dec == 8'h00 && score_d != TGT_BCD) tup_d = 1'b1;
                        end else begin
                            presc_d = presc_q + 1'b1;
                        end
                    end
                end
                if (MSM_STATE == MSM_START) begin
                    state_d = ST_IDLE;
                end else if (MSM_STATE == MSM_END_W || MSM_STATE == MSM_END_L || win_d || tup_d) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (MSM_STATE == MSM_START) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ref_d    = ref_q + 1'b1;
        digit_d  = digit_q;
        nib      = 4'd0;
        nib_mode = SEG_MODE_DIGIT;
        if (ref_q == RW'(REFRESH_DIV - 1)) begin
            ref_d   = '0;
            digit_d = digit_q + 2'd1;
        end
        case (digit_d)
            2'd0: nib = score_q[3:0];
            2'd1: nib = score_q[7:4];
            2'd2: begin
                nib      = sec_q[3:0];
                nib_mode = mode_q ? SEG_MODE_DIGIT : SEG_MODE_DASH;
            end
            default: begin
                nib      = sec_q[7:4];
                nib_mode = mode_q ? SEG_MODE_DIGIT : SEG_MODE_DASH;
            end
        endcase
        sel_d = ~(4'b0001 << digit_d);
    end

    seg7_decoder u_seg7 (
        .bcd_i  (nib),
        .mode_i (nib_mode),
        .seg_o  (hex_d)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            mode_q  <= 1'b0;
            tr_q    <= 1'b0;
            edge_q  <= 1'b0;
            score_q <= 8'h00;
            sec_q   <= SEC_INIT;
            presc_q <= '0;
            win_q   <= 1'b0;
            tup_q   <= 1'b0;
            ref_q   <= '0;
            digit_q <= 2'd0;
            sel_q   <= 4'b1110;
            hex_q   <= SEG_BLANK;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            tr_q    <= TARGET_REACHED;
            edge_q  <= TARGET_REACHED & ~tr_q;
            score_q <= score_d;
            sec_q   <= sec_d;
            presc_q <= presc_d;
            win_q   <= win_d;
            tup_q   <= tup_d;
            ref_q   <= ref_d;
            digit_q <= digit_d;
            sel_q   <= sel_d;
            hex_q   <= hex_d;
        end
    end

    assign SCORE      = score_q;
    assign WIN        = win_q;
    assign TIME_UP    = tup_q;
    assign SEG_SELECT = sel_q;
    assign HEX_OUT    = hex_q;

endmodule
